// File: rtl/chain_seq_ctrl_if.sv
// Control/status bundle between the test top level and chain_seq_ctrl.
//   start, abort   : run request / cancel (master -> slave)
//   seed, iters    : run operands, sampled when start is accepted
//   busy, done     : run in progress / one-cycle end-of-run pulse
//   pass, err_cnt  : outcome of the current or last run
//   result         : chain output captured at the last compare
interface chain_seq_ctrl_if #(parameter int W = 32);
  logic         start;
  logic         abort;
  logic [W-1:0] seed;
  logic [7:0]   iters;
  logic         busy;
  logic         done;
  logic         pass;
  logic [7:0]   err_cnt;
  logic [W-1:0] result;

  modport master (output start, abort, seed, iters,
                  input  busy, done, pass, err_cnt, result);
  modport slave  (input  start, abort, seed, iters,
                  output busy, done, pass, err_cnt, result);
endinterface

// File: rtl/chain_seq_ctrl.sv
// Sequencer for a chain of CNT registered increment stages (each adds STEP).
// Drives an operand into the chain, waits out the chain latency, compares
// the chain output against the expected value and repeats for iters rounds,
// feeding the expected value (not the observed one) back in.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   ctl        : control/status interface (slave side)
//   chain_in   : registered operand into stage 0
//   chain_out  : output of the last stage
module chain_seq_ctrl #(
  parameter int W    = 32,
  parameter int CNT  = 5,
  parameter int STEP = 1,
  parameter int LAT  = CNT
) (
  input  logic            clk,
  input  logic            rst,
  chain_seq_ctrl_if.slave ctl,
  output logic [W-1:0]    chain_in,
  input  logic [W-1:0]    chain_out
);

  localparam logic [W-1:0] INC = W'(CNT * STEP);
  localparam int           WC  = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [W-1:0]  exp_val;
  logic [7:0]    remaining;
  logic [WC-1:0] wcnt;
  logic          busy, done, pass;
  logic [7:0]    err_cnt;
  logic [W-1:0]  result;
  logic          miss;

  assign miss = (chain_out != exp_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chain_in  <= '0;
      exp_val   <= '0;
      remaining <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ctl.start) begin
            if (ctl.iters != 8'd0) begin
              chain_in  <= ctl.seed;
              exp_val   <= ctl.seed + INC;
              remaining <= ctl.iters;
              wcnt      <= WC'(LAT);
              err_cnt   <= '0;
              pass      <= 1'b0;
              busy      <= 1'b1;
              state     <= WAIT;
            end else begin
              // Zero-length run: report the seed straight back.
              result  <= ctl.seed;
              pass    <= 1'b1;
              err_cnt <= '0;
              done    <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (ctl.abort) begin
            // Outcome registers freeze; no done pulse.
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wcnt != '0) begin
            wcnt <= wcnt - WC'(1);
          end else begin
            result    <= chain_out;
            remaining <= remaining - 8'd1;
            if (miss && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (remaining > 8'd1) begin
              // Feed the expected value so one bad round cannot poison the rest.
              chain_in <= exp_val;
              exp_val  <= exp_val + INC;
              wcnt     <= WC'(LAT);
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_cnt == 8'd0) && !miss;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.busy    = busy;
  assign ctl.done    = done;
  assign ctl.pass    = pass;
  assign ctl.err_cnt = err_cnt;
  assign ctl.result  = result;

endmodule

// File: doc/chain_seq_ctrl.md
Name: chain_seq_ctrl

Overview:
- Sequencer for a chain of CNT registered increment stages. Each stage adds STEP per clock, so the chain has a latency of CNT cycles.
- On start, the block drives a seed into the chain input and waits out the chain latency. It then samples the chain output and checks it against the expected value.
- It repeats for a programmable number of iterations, feeding each expected value back in as the next operand, and reports pass/fail, an error count and the last result.
- It sits between the test top level and the stage chain. It owns the chain input register.

Parameters:
- W, 32, datapath width of chain_in, chain_out, seed and result.
- CNT, 5, number of increment stages in the chain.
- STEP, 1, increment applied by each stage.
- LAT, CNT, chain latency in clock edges, from a chain_in update to the last stage capturing it.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  input  1  stops the current run and returns to IDLE; no done pulse.
- seed  input  W  initial operand, sampled on the accepted start edge.
- iters  input  8  iteration count, sampled on the accepted start edge.
- chain_in  output  W  registered operand driven into stage 0.
- chain_out  input  W  output of the last stage.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  1 if every iteration of the last run matched; held until the next start.
- err_cnt  output  8  mismatch count for the current or last run; saturates at 255.
- result  output  W  chain_out value captured at the last compare.

Behaviour:
- Reset (clk edge with rst=1, whether idle or mid-run):
  - state=IDLE.
  - chain_in, result, err_cnt, internal expected and iteration/wait counters all 0.
  - busy=0, done=0, pass=0.
  - Reset has priority over abort and start.
- States: IDLE, WAIT.
- IDLE, start=1, iters!=0 (edge S):
  - chain_in<=seed; exp<=seed+CNT*STEP (mod 2^W).
  - remaining<=iters; wcnt<=LAT; err_cnt<=0; pass<=0; busy<=1.
  - state<=WAIT.
- IDLE, start=1, iters==0:
  - Next edge: result<=seed, pass<=1, err_cnt<=0, done<=1.
  - busy stays 0; state stays IDLE.
- WAIT:
  - While wcnt!=0, each edge decrements wcnt.
  - On the edge where wcnt==0 (the compare edge, LAT+1 edges after the chain_in update):
    - result<=chain_out.
    - If chain_out!=exp, err_cnt<=sat(err_cnt+1).
    - remaining<=remaining-1.
  - At the compare edge, if remaining>1:
    - chain_in<=exp (the expected value, not chain_out, so errors do not propagate).
    - exp<=exp+CNT*STEP (mod 2^W); wcnt<=LAT; stay in WAIT.
  - At the compare edge, if remaining==1:
    - done<=1 for one cycle; busy<=0.
    - pass<=1 if no mismatch in the run, including this compare; else 0.
    - state<=IDLE. chain_in holds its last value.
- Run timing: done is high in the cycle after edge S+iters*(LAT+1).
- Start while busy: ignored, with no effect on any output.
- abort=1 in WAIT:
  - Next edge: state<=IDLE, busy<=0, done stays 0.
  - pass, result and err_cnt freeze at their current values. chain_in holds.
- abort in IDLE: no effect.
- abort and start together in IDLE: start is honoured.
- Arithmetic: all sums truncated to W bits; wrap-around is legal and expected. CNT*STEP is evaluated at elaboration and truncated to W bits.
- Back-to-back runs: a start in the cycle where done=1 is accepted, since state is already IDLE.

Test Plan:
- Basic run: CNT=5, STEP=1, seed=0x1234, iters=1 → chain_in=0x1234 after S; done after S+6; result=0x1239, pass=1, err_cnt=0.
- Multi-iteration with wrap: seed=0xFFFF_FFFD, iters=3 → compares see 0x2, 0x7, 0xC; done after S+18; result=0xC, pass=1.
- Fault injection: bench chain adds 2 at one stage during iteration 2 only, seed=0, iters=3 → err_cnt=1, pass=0. The iteration-3 operand is still 0xA, so result=0xF.
- iters=0: seed=0x55 → done one cycle after start, busy never high, result=0x55, pass=1.
- Abort and ignored start:
  - start pulsed again at S+2 → ignored.
  - abort at S+3 → busy=0 at S+4; done never pulses; err_cnt=0.
  - A new start is then accepted normally.
- Reset mid-run: rst=1 at S+4 → all outputs 0 next cycle. The following start with seed=0x10, iters=1 gives result=0x15, pass=1.
